// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and timing-derivation helpers for sprite_engine.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Coordinates are held at a fixed width; every supported raster fits in it
    localparam int c_COORD_W = 12;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic [c_COORD_W-1:0] x;
        logic [c_COORD_W-1:0] y;
        color_t               color;
        logic                 enable;
        logic                 scale2;
    } sprite_regs_t;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync_len, input int bp);
        return active + fp + sync_len + bp;
    endfunction

    function automatic int coord_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel divider, raster counters, sync/active flags and the
//               start-of-vblank commit strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import sprite_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = coord_width(H_TOTAL),
    localparam int YW      = coord_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_pix_en,
    output logic [XW-1:0] o_h_cnt,
    output logic [YW-1:0] o_v_cnt,
    output logic          o_hsync_act,
    output logic          o_vsync_act,
    output logic          o_active,
    output logic          o_commit
);

    localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [XW-1:0]   c_H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]   c_V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]   c_V_PRE_BL = YW'(V_ACTIVE - 1);

    // One extra bit so sync-end constants equal to the total cannot truncate
    localparam logic [XW:0] c_HS_START = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] c_HS_END   = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW:0] c_H_ACT    = (XW+1)'(H_ACTIVE);
    localparam logic [YW:0] c_VS_START = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] c_VS_END   = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW:0] c_V_ACT    = (YW+1)'(V_ACTIVE);

    logic [c_DW-1:0] r_div;
    logic [XW-1:0]   r_h_cnt;
    logic [YW-1:0]   r_v_cnt;
    logic            w_pix_en;
    logic [XW:0]     w_h_ext;
    logic [YW:0]     w_v_ext;

    assign w_pix_en = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_en) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + YW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + XW'(1);
            end
        end
    end

    assign w_h_ext = {1'b0, r_h_cnt};
    assign w_v_ext = {1'b0, r_v_cnt};

    assign o_pix_en    = w_pix_en;
    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_hsync_act = (w_h_ext >= c_HS_START) && (w_h_ext < c_HS_END);
    assign o_vsync_act = (w_v_ext >= c_VS_START) && (w_v_ext < c_VS_END);
    assign o_active    = (w_h_ext < c_H_ACT) && (w_v_ext < c_V_ACT);

    // The tick that moves the raster onto (h=0, v=V_ACTIVE): first vblank line
    assign o_commit = w_pix_en && (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_PRE_BL);

endmodule
`default_nettype wire

// File: rtl/sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : sprite_engine
// Description : Multi-sprite VGA renderer with double-buffered sprite
//               registers committed at the start of vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int     CLK_DIV   = 4,
    parameter int     H_ACTIVE  = 640,
    parameter int     H_FP      = 16,
    parameter int     H_SYNC    = 96,
    parameter int     H_BP      = 48,
    parameter int     V_ACTIVE  = 480,
    parameter int     V_FP      = 10,
    parameter int     V_SYNC    = 2,
    parameter int     V_BP      = 33,
    parameter bit     SYNC_POL  = 1'b0,
    parameter int     N_SPRITES = 4,
    parameter int     SPRITE_W  = 32,
    parameter int     SPRITE_H  = 32,
    parameter color_t BG_COLOR  = 12'h000,
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = coord_width(H_TOTAL),
    localparam int YW      = coord_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_button,
    input  logic          wr_en,
    input  logic [3:0]    wr_idx,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [11:0]   wr_color,
    input  logic          wr_enable,
    input  logic          wr_scale2,
    output logic          frame_start,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue
);

    localparam logic [4:0] c_N_SPR  = 5'(N_SPRITES);
    localparam int c_XY_W   = (XW > YW) ? XW : YW;
    localparam int c_SPAN   = 2 * ((SPRITE_W > SPRITE_H) ? SPRITE_W : SPRITE_H);
    localparam int c_SPAN_W = $clog2(c_SPAN + 1);
    // Wide enough that x + width never wraps, so off-edge sprites clip
    localparam int c_CW     = ((c_XY_W > c_SPAN_W) ? c_XY_W : c_SPAN_W) + 1;

    logic          w_pix_en;
    logic [XW-1:0] w_h_cnt;
    logic [YW-1:0] w_v_cnt;
    logic          w_hsync_act;
    logic          w_vsync_act;
    logic          w_active;
    logic          w_commit;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (reset_button),
        .o_pix_en    (w_pix_en),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_hsync_act (w_hsync_act),
        .o_vsync_act (w_vsync_act),
        .o_active    (w_active),
        .o_commit    (w_commit)
    );

    logic                 w_wr_ok;
    logic [c_CW-1:0]      w_h;
    logic [c_CW-1:0]      w_v;
    logic [N_SPRITES-1:0] w_hit;
    color_t               w_spr_color [N_SPRITES];
    color_t               w_pix_color;

    assign w_wr_ok = wr_en && ({1'b0, wr_idx} < c_N_SPR);
    assign w_h     = c_CW'(w_h_cnt);
    assign w_v     = c_CW'(w_v_cnt);

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
        localparam logic [3:0] c_IDX = 4'(gi);

        sprite_regs_t    r_shadow;
        sprite_regs_t    r_active;
        logic [c_CW-1:0] w_x0;
        logic [c_CW-1:0] w_y0;
        logic [c_CW-1:0] w_w;
        logic [c_CW-1:0] w_hgt;

        // Commit reads the shadow before this edge's write, so a write
        // coinciding with the commit lands in the following frame.
        always_ff @(posedge clk or posedge reset_button) begin
            if (reset_button) begin
                r_shadow <= '0;
                r_active <= '0;
            end else begin
                if (w_commit) begin
                    r_active <= r_shadow;
                end
                if (w_wr_ok && (wr_idx == c_IDX)) begin
                    r_shadow <= '{x:      c_COORD_W'(wr_x),
                                  y:      c_COORD_W'(wr_y),
                                  color:  wr_color,
                                  enable: wr_enable,
                                  scale2: wr_scale2};
                end
            end
        end

        assign w_x0  = c_CW'(r_active.x);
        assign w_y0  = c_CW'(r_active.y);
        assign w_w   = r_active.scale2 ? c_CW'(2 * SPRITE_W) : c_CW'(SPRITE_W);
        assign w_hgt = r_active.scale2 ? c_CW'(2 * SPRITE_H) : c_CW'(SPRITE_H);

        assign w_hit[gi] = r_active.enable
                        && (w_h >= w_x0) && (w_h < (w_x0 + w_w))
                        && (w_v >= w_y0) && (w_v < (w_y0 + w_hgt));

        assign w_spr_color[gi] = r_active.color;
    end

    // Scanning from the top index down leaves the lowest hitting index in place
    always_comb begin
        w_pix_color = BG_COLOR;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_pix_color = w_spr_color[i];
            end
        end
    end

    logic   r_hsync;
    logic   r_vsync;
    color_t r_rgb;

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_rgb   <= '0;
        end else if (w_pix_en) begin
            r_hsync <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_rgb   <= w_active ? w_pix_color : '0;
        end
    end

    assign frame_start = w_commit;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];

endmodule
`default_nettype wire
